rspi_arbiter: RTL

//  Shares the single reserved-SPI spi_core (flash + RAM chip selects) between two requesters.

---
 rtl/rspi_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rspi_arbiter.sv
// Shares the single reserved-SPI core between the bootloader (requester 0) and mem_ctrl (requester 1).
// A grant covers a whole multi-byte transaction and owners are separated by a chip-select guard gap.
module rspi_arbiter #(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter bit          ROUND_ROBIN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       rq0_req,
    output logic       rq0_gnt,
    input  logic [7:0] rq0_data_tx,
    input  logic       rq0_txn_start,
    input  logic       rq0_force_clock,
    input  logic       rq0_flash_ce_n,
    input  logic       rq0_ram_ce_n,
    output logic [7:0] rq0_data_rx,
    output logic       rq0_txn_done,

    input  logic       rq1_req,
    output logic       rq1_gnt,
    input  logic [7:0] rq1_data_tx,
    input  logic       rq1_txn_start,
    input  logic       rq1_force_clock,
    input  logic       rq1_flash_ce_n,
    input  logic       rq1_ram_ce_n,
    output logic [7:0] rq1_data_rx,
    output logic       rq1_txn_done,

    output logic [7:0] spi_data_tx,
    output logic       spi_txn_start,
    output logic       spi_force_clock,
    input  logic [7:0] spi_data_rx,
    input  logic       spi_txn_done,
    output logic       spi_flash_ce_n,
    output logic       spi_ram_ce_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OWN0,
        S_OWN1,
        S_DRAIN,
        S_GUARD
    } state_t;

    localparam logic [3:0] GUARD_LAST    = (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);
    localparam state_t     RELEASE_STATE = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;

    state_t     r_state;
    logic       r_owner;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_in_flight;
    logic       r_last_owner;
    logic [3:0] r_guard_cnt;

    logic       w_route;
    logic       w_draining;
    logic       w_owner_req;
    logic       w_pick;
    logic       w_in_flight_nxt;

    assign w_route     = (r_state == S_OWN0) || (r_state == S_OWN1) || (r_state == S_DRAIN);
    assign w_draining  = (r_state == S_DRAIN);
    assign w_owner_req = r_owner ? rq1_req : rq0_req;

    // Contention goes to the requester that did not win last time, or always to 0 in fixed mode.
    assign w_pick = (rq0_req && rq1_req) ? (ROUND_ROBIN ? ~r_last_owner : 1'b0) : rq1_req;

    always_comb begin
        // NOTE: every output gets a default before the branches so no path can infer a latch.
        spi_data_tx     = '0;
        spi_txn_start   = 1'b0;
        spi_force_clock = 1'b0;
        spi_flash_ce_n  = 1'b1;
        spi_ram_ce_n    = 1'b1;
        rq0_data_rx     = '0;
        rq0_txn_done    = 1'b0;
        rq1_data_rx     = '0;
        rq1_txn_done    = 1'b0;
        if (w_route) begin
            if (r_owner) begin
                spi_data_tx     = rq1_data_tx;
                spi_txn_start   = rq1_txn_start && !w_draining;
                spi_force_clock = rq1_force_clock;
                spi_flash_ce_n  = rq1_flash_ce_n;
                spi_ram_ce_n    = rq1_ram_ce_n;
                rq1_data_rx     = spi_data_rx;
                rq1_txn_done    = spi_txn_done;
            end else begin
                spi_data_tx     = rq0_data_tx;
                spi_txn_start   = rq0_txn_start && !w_draining;
                spi_force_clock = rq0_force_clock;
                spi_flash_ce_n  = rq0_flash_ce_n;
                spi_ram_ce_n    = rq0_ram_ce_n;
                rq0_data_rx     = spi_data_rx;
                rq0_txn_done    = spi_txn_done;
            end
        end
    end

    // A start in the same cycle as a done begins a new byte, so start wins.
    assign w_in_flight_nxt = spi_txn_start || (r_in_flight && !spi_txn_done);

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset; all state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_in_flight  <= 1'b0;
            r_last_owner <= 1'b1;
            r_guard_cnt  <= '0;
        end else begin
            r_in_flight <= w_in_flight_nxt;
            case (r_state)
                S_IDLE: begin
                    if (rq0_req || rq1_req) begin
                        r_owner      <= w_pick;
                        r_last_owner <= w_pick;
                        r_gnt0       <= ~w_pick;
                        r_gnt1       <= w_pick;
                        r_state      <= w_pick ? S_OWN1 : S_OWN0;
                    end
                end
                S_OWN0, S_OWN1: begin
                    if (!w_owner_req) begin
                        if (w_in_flight_nxt) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= RELEASE_STATE;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (spi_txn_done) begin
                        r_state <= RELEASE_STATE;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                    end
                end
                S_GUARD: begin
                    if (r_guard_cnt == GUARD_LAST) begin
                        r_guard_cnt <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    assign rq0_gnt = r_gnt0;
    assign rq1_gnt = r_gnt1;

endmodule
